// File: rtl/ppi_pkg.sv
// rtl/ppi_pkg.sv - shared constants and FSM state encoding for the 8255 bus sequencer
package ppi_pkg;

    localparam logic [1:0] PPI_ADDR_A    = 2'd0;
    localparam logic [1:0] PPI_ADDR_B    = 2'd1;
    localparam logic [1:0] PPI_ADDR_C    = 2'd2;
    localparam logic [1:0] PPI_ADDR_CTRL = 2'd3;

    typedef logic [2:0] ppi_state_t;

    localparam ppi_state_t ST_INIT   = 3'd0;
    localparam ppi_state_t ST_IDLE   = 3'd1;
    localparam ppi_state_t ST_SETUP  = 3'd2;
    localparam ppi_state_t ST_STROBE = 3'd3;
    localparam ppi_state_t ST_HOLD   = 3'd4;

    // Mode 0, ports A, B and C all inputs.
    localparam logic [7:0] PPI_INIT_CW_DEFAULT = 8'h9B;

endpackage

// File: rtl/ppi_bus_sequencer_arb.sv
// rtl/ppi_bus_sequencer_arb.sv - 2-way round-robin arbiter (ppi_rr_arb) holding last_grant
module ppi_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    input  logic accept_id,
    output logic grant_any,
    output logic grant_id
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = accept_id;
        end
        grant_any = valid0 | valid1;
        grant_id  = (valid0 & valid1) ? ~last_grant_q : ~valid0;
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ppi_bus_sequencer.sv
// rtl/ppi_bus_sequencer.sv - arbitrated 8255 bus-cycle controller; PPI_INIT_EN adds a start-up control-word write
module ppi_bus_sequencer
    import ppi_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter logic [7:0]  INIT_CW    = PPI_INIT_CW_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_wr,
    input  logic [1:0] req0_addr,
    input  logic [7:0] req0_wdata,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_wr,
    input  logic [1:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [1:0] a0_a1,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in
);

    ppi_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       cmd_id_q, cmd_id_d, cmd_wr_q, cmd_wr_d;
    logic [1:0] cmd_addr_q, cmd_addr_d;
    logic [7:0] cmd_wdata_q, cmd_wdata_d, cap_q, cap_d;
    logic       init_q, init_d;
    logic       req0_ready_q, req0_ready_d, req1_ready_q, req1_ready_d;
    logic       rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       busy_q, busy_d, cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
    logic [1:0] a0_a1_q, a0_a1_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic       acc0, acc1, accept, acc_id, sel_wr, illegal, bus_d, grant_any, grant_id;
    logic [1:0] sel_addr;
    logic [7:0] sel_wdata;

    assign acc0      = req0_valid & req0_ready_q;
    assign acc1      = req1_valid & req1_ready_q;
    assign accept    = acc0 | acc1;
    assign acc_id    = acc1;
    assign sel_wr    = acc_id ? req1_wr : req0_wr;
    assign sel_addr  = acc_id ? req1_addr : req0_addr;
    assign sel_wdata = acc_id ? req1_wdata : req0_wdata;
    assign illegal   = accept & ~sel_wr & (sel_addr == PPI_ADDR_CTRL);

    ppi_rr_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .accept    (accept),
        .accept_id (acc_id),
        .grant_any (grant_any),
        .grant_id  (grant_id)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_id_d    = cmd_id_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cap_d       = cap_q;
        init_d      = init_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 8'h00;
        case (state_q)
`ifdef PPI_INIT_EN
            ST_INIT: begin
                state_d     = ST_SETUP;
                cnt_d       = 4'(SETUP_CYC - 1);
                cmd_wr_d    = 1'b1;
                cmd_addr_d  = PPI_ADDR_CTRL;
                cmd_wdata_d = INIT_CW;
                init_d      = 1'b1;
            end
`endif
            ST_IDLE: begin
                if (accept) begin
                    cmd_id_d    = acc_id;
                    cmd_wr_d    = sel_wr;
                    cmd_addr_d  = sel_addr;
                    cmd_wdata_d = sel_wdata;
                    if (illegal) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_id_d    = acc_id;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = 4'(SETUP_CYC - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = 4'(STROBE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = 4'(HOLD_CYC - 1);
                    if (!cmd_wr_q) begin
                        cap_d = data_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = ~init_q;
                    rsp_id_d    = ~init_q & cmd_id_q;
                    rsp_rdata_d = (init_q | cmd_wr_q) ? 8'h00 : cap_q;
                    init_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every pin is registered, so drive from the state being entered.
        bus_d        = (state_d == ST_SETUP) | (state_d == ST_STROBE) | (state_d == ST_HOLD);
        cs_d         = ~bus_d;
        rd_d         = ~((state_d == ST_STROBE) & ~cmd_wr_d);
        wr_d         = ~((state_d == ST_STROBE) & cmd_wr_d);
        a0_a1_d      = bus_d ? cmd_addr_d : 2'd0;
        data_oe_d    = bus_d & cmd_wr_d;
        data_out_d   = data_oe_d ? cmd_wdata_d : 8'h00;
        busy_d       = (state_d != ST_IDLE);
        req0_ready_d = (state_d == ST_IDLE) & ~accept & grant_any & ~grant_id;
        req1_ready_d = (state_d == ST_IDLE) & ~accept & grant_any & grant_id;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef PPI_INIT_EN
            state_q <= ST_INIT;
`else
            state_q <= ST_IDLE;
`endif
            cnt_q        <= 4'd0;
            cmd_id_q     <= 1'b0;
            cmd_wr_q     <= 1'b0;
            cmd_addr_q   <= 2'd0;
            cmd_wdata_q  <= 8'h00;
            cap_q        <= 8'h00;
            init_q       <= 1'b0;
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 8'h00;
            busy_q       <= 1'b0;
            cs_q         <= 1'b1;
            rd_q         <= 1'b1;
            wr_q         <= 1'b1;
            a0_a1_q      <= 2'd0;
            data_out_q   <= 8'h00;
            data_oe_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_id_q     <= cmd_id_d;
            cmd_wr_q     <= cmd_wr_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cap_q        <= cap_d;
            init_q       <= init_d;
            req0_ready_q <= req0_ready_d;
            req1_ready_q <= req1_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            busy_q       <= busy_d;
            cs_q         <= cs_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            a0_a1_q      <= a0_a1_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
        end
    end

    assign req0_ready = req0_ready_q;
    assign req1_ready = req1_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign busy       = busy_q;
    assign cs         = cs_q;
    assign rd         = rd_q;
    assign wr         = wr_q;
    assign a0_a1      = a0_a1_q;
    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// tb/tb_ppi_bus_sequencer.sv - self-checking bench for ppi_bus_sequencer (default timing 1/2/1)
module tb_ppi_bus_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req0_wr = 1'b0, req1_valid = 1'b0, req1_wr = 1'b0;
    logic [1:0] req0_addr = 2'd0, req1_addr = 2'd0;
    logic [7:0] req0_wdata = 8'h00, req1_wdata = 8'h00, data_in = 8'h00;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy, cs, rd, wr, data_oe;
    logic [7:0] rsp_rdata, data_out;
    logic [1:0] a0_a1;

    ppi_bus_sequencer dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .cs(cs), .rd(rd), .wr(wr), .a0_a1(a0_a1),
        .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    typedef struct {
        logic       id;
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdin;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    exp_t       sb[$];
    logic [7:0] cur_exp_rdata = 8'h00;
    logic       cur_exp_err = 1'b0;
    logic       last_id = 1'b1;
    vec_t       vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expectation pushed on each observed accept, popped on each response.
    always @(negedge clk) begin
        if (!reset) begin
            if (req0_valid && req0_ready) begin
                sb.push_back('{1'b0, cur_exp_rdata, cur_exp_err});
                last_id = 1'b0;
            end
            if (req1_valid && req1_ready) begin
                sb.push_back('{1'b1, cur_exp_rdata, cur_exp_err});
                last_id = 1'b1;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected none at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic run_cmd(input vec_t v);
        int   n;
        logic ill, rdy, strobe;
        ill = !v.wr && (v.addr == 2'd3);
        @(posedge clk); #1;
        cur_exp_rdata = v.exp_rdata;
        cur_exp_err   = v.exp_err;
        data_in       = v.rdin;
        if (v.id) begin
            req1_wr = v.wr; req1_addr = v.addr; req1_wdata = v.wdata; req1_valid = 1'b1;
        end else begin
            req0_wr = v.wr; req0_addr = v.addr; req0_wdata = v.wdata; req0_valid = 1'b1;
        end
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
            rdy = v.id ? req1_ready : req0_ready;
        end
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no ready expected ready within 20 cycles");
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 1; k <= (ill ? 2 : 5); k++) begin
            if (k > 1) @(negedge clk);
            else @(negedge clk);
            strobe = (k == 2) || (k == 3);
            if (ill) begin
                chk("ill_cs", 32'(cs), 32'd1);
                chk("ill_rsp_valid", 32'(rsp_valid), (k == 1) ? 32'd1 : 32'd0);
            end else if (k <= 4) begin
                chk("cs", 32'(cs), 32'd0);
                chk("rd", 32'(rd), 32'(!(!v.wr && strobe)));
                chk("wr", 32'(wr), 32'(!(v.wr && strobe)));
                chk("a0_a1", 32'(a0_a1), 32'(v.addr));
                chk("data_oe", 32'(data_oe), 32'(v.wr));
                if (v.wr) chk("data_out", 32'(data_out), 32'(v.wdata));
                chk("busy", 32'(busy), 32'd1);
                chk("rsp_early", 32'(rsp_valid), 32'd0);
            end else begin
                chk("cs_end", 32'(cs), 32'd1);
                chk("rd_end", 32'(rd), 32'd1);
                chk("wr_end", 32'(wr), 32'd1);
                chk("rsp_valid", 32'(rsp_valid), 32'd1);
            end
        end
    endtask

    initial begin
        int         acc_cnt, c0, c1, n;
        logic       first;
        logic       gids[$];
        int         gtimes[$];

        vecs[0] = '{1'b0, 1'b1, 2'd0, 8'h54, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 2'd1, 8'h00, 8'h45, 8'h45, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 2'd3, 8'h00, 8'h77, 8'h00, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 2'd3, 8'h80, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 2'd2, 8'h00, 8'hA5, 8'hA5, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 2'd2, 8'h3C, 8'hFF, 8'h00, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_rd", 32'(rd), 32'd1);
        chk("rst_wr", 32'(wr), 32'd1);
        chk("rst_a0_a1", 32'(a0_a1), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_data_oe", 32'(data_oe), 32'd0);
        chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_err, rsp_rdata}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

`ifdef PPI_INIT_EN
        req0_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!cs) begin
                n++;
                chk("init_addr", 32'(a0_a1), 32'd3);
                chk("init_data", 32'(data_out), 32'h9B);
                chk("init_ready", 32'({req0_ready, req1_ready}), 32'd0);
            end
            if (req0_ready) break;
        end
        chk("init_cs_cycles", 32'(n), 32'd4);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (6) @(posedge clk);
        sb.delete();
`endif

        foreach (vecs[i]) run_cmd(vecs[i]);

        // Both requesters valid: grants alternate, accepts every 5 cycles.
        first = ~last_id;
        cur_exp_rdata = 8'h00;
        cur_exp_err = 1'b0;
        @(posedge clk); #1;
        req0_wr = 1'b1; req0_addr = 2'd0; req0_wdata = 8'h11; req0_valid = 1'b1;
        req1_wr = 1'b1; req1_addr = 2'd1; req1_wdata = 8'h22; req1_valid = 1'b1;
        c0 = 0;
        c1 = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin gids.push_back(1'b0); gtimes.push_back(cyc); c0++; end
            if (req1_valid && req1_ready) begin gids.push_back(1'b1); gtimes.push_back(cyc); c1++; end
            if (c0 + c1 >= 8) break;
            @(posedge clk); #1;
            if (c0 >= 4) req0_valid = 1'b0;
            if (c1 >= 4) req1_valid = 1'b0;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        acc_cnt = gids.size();
        chk("arb_accepts", 32'(acc_cnt), 32'd8);
        for (int i = 0; i < acc_cnt; i++) begin
            chk("arb_grant", 32'(gids[i]), 32'(first ^ i[0]));
            if (i > 0) chk("arb_spacing", 32'(gtimes[i] - gtimes[i-1]), 32'd5);
        end
        repeat (6) @(posedge clk);

        // Reset in the second STROBE cycle of a write.
        @(posedge clk); #1;
        req0_wr = 1'b1; req0_addr = 2'd2; req0_wdata = 8'h66; req0_valid = 1'b1;
        n = 0;
        while (!req0_ready && n < 20) begin @(negedge clk); n++; end
        chk("mid_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_wr_low", 32'(wr), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        last_id = 1'b1;
        @(negedge clk);
        chk("mid_cs", 32'(cs), 32'd1);
        chk("mid_wr", 32'(wr), 32'd1);
        chk("mid_oe", 32'(data_oe), 32'd0);
        chk("mid_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
        end
        run_cmd('{1'b0, 1'b1, 2'd1, 8'hC3, 8'h00, 8'h00, 1'b0});

        n = 0;
        while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
